ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 5: ps2_clock samples required stable on each side of a falling edge.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: code FIFO entries, power of 2, >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: clock cycles without a falling edge before a partial frame is aborted.
REQ-004 SHALL have port clock, input, 1: system clock, all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports ps2_clock and ps2_data, input, 1 each: raw PS/2 lines, asynchronous to clock.
REQ-007 SHALL have port code_data, output, 8: scan code at FIFO head.
REQ-008 SHALL have ports code_break and code_ext, output, 1 each: F0 / E0 prefix seen before the head code.
REQ-009 SHALL have port code_valid, output, 1: FIFO non-empty.
REQ-010 SHALL have port code_ready, input, 1: consumer accepts the head entry.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-012 SHALL have ports frame_error and overflow, output, 1 each: single-cycle error pulses.

Function
REQ-013 SHALL pass ps2_clock and ps2_data through 2-flop synchronisers before any use.
REQ-014 SHALL detect a falling edge only when the 2*FILTER_LEN sample history reads FILTER_LEN ones (older) then FILTER_LEN zeros (newer); exactly one edge event per transition; shorter glitches ignored.
REQ-015 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on edge events.
REQ-016 IDLE: ps2_data=0 at an edge -> DATA with bit count 0; ps2_data=1 ignored.
REQ-017 DATA: shift in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: capture the parity bit -> STOP.
REQ-019 STOP: frame good iff ps2_data=1 and data plus parity hold an odd count of ones; otherwise frame_error pulses one cycle; always -> IDLE.
REQ-020 Outside IDLE, a cycle counter clears on every edge; on reaching TIMEOUT_CYCLES the FSM SHALL go IDLE, discard the partial byte, and pulse frame_error.
REQ-021 A good byte SHALL be pushed into the FIFO as {break, ext, byte}, appearing at the outputs one cycle after the STOP edge cycle (first-word-fall-through).
REQ-022 Pop SHALL occur when code_valid and code_ready are high on the same cycle; outputs then show the next entry the following cycle.
REQ-023 Push to a full FIFO SHALL be dropped, pulse overflow, and leave contents unchanged, unless a pop occurs the same cycle, in which case both succeed.
REQ-024 When code_valid=0, code_data, code_break and code_ext SHALL read 0.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL track pushes minus pops exactly.

Reset
REQ-026 While reset is high, the block SHALL force: FSM IDLE, FIFO empty, fifo_count=0, all outputs 0, prefix flags cleared.
REQ-027 Synchronisers and sample history SHALL reset to all ones (idle bus), so no false edge follows reset.
REQ-028 A frame in progress at reset SHALL be discarded without frame_error.

Configuration
REQ-029 With PS2_EXT_DECODE_EN defined: byte E0 sets the ext flag and byte F0 sets the break flag, and neither is pushed; the next non-prefix byte is pushed with both flags, which then clear; a bad or timed-out frame clears both flags.
REQ-030 Without PS2_EXT_DECODE_EN: every good byte, E0 and F0 included, SHALL be pushed raw; code_break and code_ext SHALL be tied 0.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, code_ready=0 -> code_valid=1, code_data=0x1C, break=0, ext=0, one cycle after the STOP edge; fifo_count=1.
REQ-032 Frames F0,1C -> single entry 0x1C, break=1. Frames E0,F0,75 -> single entry 0x75, ext=1, break=1. Without the macro -> three raw entries.
REQ-033 Frame 0x15 with wrong parity bit -> no push, frame_error pulse, fifo_count unchanged.
REQ-034 Nine good frames 0x01..0x09 with code_ready=0 and FIFO_DEPTH=8 -> fifo_count=8, overflow pulse on the 9th; popping then yields 0x01..0x08 in order.
REQ-035 Clock stopped after 4 data bits -> frame_error after TIMEOUT_CYCLES; the next full frame 0x2D is received correctly.
REQ-036 ps2_clock low glitch of FILTER_LEN-1 samples mid-frame -> no bit shifted; the frame still decodes correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver feeding a first-word-fall-through scan-code FIFO
//
// Purpose:
//    Synchronises the raw PS/2 lines and filters ps2_clock falling edges.
//    Decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
//    queues good bytes in a FIFO. Partial frames are aborted after
//    TIMEOUT_CYCLES clock cycles without a falling edge.
//
// Optional feature macro: PS2_EXT_DECODE_EN
//    When defined, E0/F0 prefix bytes are absorbed into ext/break flags and
//    stored alongside the next non-prefix byte. When undefined, every good
//    byte is queued raw and code_break/code_ext are tied low.
//
// Ports:
//    clock        in   system clock, rising edge
//    reset        in   asynchronous, active-high reset
//    ps2_clock    in   raw PS/2 clock line (asynchronous)
//    ps2_data     in   raw PS/2 data line (asynchronous)
//    code_data    out  [7:0] scan code at FIFO head (0 when empty)
//    code_break   out  F0 prefix preceded the head code (0 when empty)
//    code_ext     out  E0 prefix preceded the head code (0 when empty)
//    code_valid   out  FIFO non-empty
//    code_ready   in   consumer accepts head entry
//    fifo_count   out  [$clog2(FIFO_DEPTH):0] current occupancy
//    frame_error  out  one-cycle pulse: bad parity/stop or timeout
//    overflow     out  one-cycle pulse: good byte dropped on a full FIFO

module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 5,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2_clock,
   input  logic                          ps2_data,
   output logic [7:0]                    code_data,
   output logic                          code_break,
   output logic                          code_ext,
   output logic                          code_valid,
   input  logic                          code_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_error,
   output logic                          overflow
);

   localparam int HW = 2 * FILTER_LEN;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_EXT_DECODE_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif

   // FILTER_LEN stable highs (older) followed by FILTER_LEN stable lows (newer)
   localparam logic [HW-1:0] EDGE_PAT     = {{FILTER_LEN{1'b1}}, {FILTER_LEN{1'b0}}};
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_C      = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------------------------------------------------------
   // Synchronisers and edge filter. Reset to ones (idle bus) so the
   // history cannot present a falling edge right after reset.
   // ---------------------------------------------------------------
   logic          r_clk_meta, r_clk_sync;
   logic          r_dat_meta, r_dat_sync;
   logic [HW-1:0] r_hist;
   logic          w_edge;
   logic          w_bit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
         r_hist     <= '1;
      end else begin
         r_clk_meta <= ps2_clock;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_data;
         r_dat_sync <= r_dat_meta;
         r_hist     <= {r_hist[HW-2:0], r_clk_sync};
      end
   end

   // The exact pattern holds for one cycle only, giving one event per edge
   assign w_edge = (r_hist == EDGE_PAT);
   assign w_bit  = r_dat_sync;

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   state_t        r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [TW-1:0] r_timer;
   logic          r_frame_error;
   logic          w_good;
   logic          w_stop_edge;
   logic          w_timeout;
   logic          w_push;
   logic [EW-1:0] w_entry;

   assign w_good      = w_bit & (^{r_shift, r_parity});
   assign w_stop_edge = (r_state == S_STOP) && w_edge;
   assign w_timeout   = (r_state != S_IDLE) && !w_edge && (r_timer == TIMEOUT_LAST);

`ifdef PS2_EXT_DECODE_EN
   logic r_brk;
   logic r_ext;
   logic w_is_prefix;

   assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
   assign w_push      = w_stop_edge && w_good && !w_is_prefix;
   assign w_entry     = {r_brk, r_ext, r_shift};
`else
   assign w_push      = w_stop_edge && w_good;
   assign w_entry     = r_shift;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_bit_cnt     <= 3'd0;
         r_shift       <= 8'd0;
         r_parity      <= 1'b0;
         r_timer       <= '0;
         r_frame_error <= 1'b0;
`ifdef PS2_EXT_DECODE_EN
         r_brk         <= 1'b0;
         r_ext         <= 1'b0;
`endif
      end else begin
         r_frame_error <= 1'b0;

         if (r_state == S_IDLE || w_edge)
            r_timer <= '0;
         else
            r_timer <= r_timer + TW'(1);

         case (r_state)
            S_IDLE: begin
               if (w_edge && !w_bit) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= 3'd0;
               end
            end
            S_DATA: begin
               if (w_edge) begin
                  r_shift   <= {w_bit, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (w_edge) begin
                  r_parity <= w_bit;
                  r_state  <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_edge) begin
                  r_state <= S_IDLE;
                  if (!w_good) begin
                     r_frame_error <= 1'b1;
`ifdef PS2_EXT_DECODE_EN
                     r_brk <= 1'b0;
                     r_ext <= 1'b0;
                  end else if (r_shift == 8'hE0) begin
                     r_ext <= 1'b1;
                  end else if (r_shift == 8'hF0) begin
                     r_brk <= 1'b1;
                  end else begin
                     r_brk <= 1'b0;
                     r_ext <= 1'b0;
`endif
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Abandon a stalled frame; never coincides with an edge
         if (w_timeout) begin
            r_state       <= S_IDLE;
            r_frame_error <= 1'b1;
`ifdef PS2_EXT_DECODE_EN
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
`endif
         end
      end
   end

   assign frame_error = r_frame_error;

   // ---------------------------------------------------------------
   // First-word-fall-through FIFO
   // ---------------------------------------------------------------
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          w_valid;
   logic          w_full;
   logic          w_pop;
   logic          w_wr;
   logic [EW-1:0] w_head;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == DEPTH_C);
   assign w_pop   = w_valid && code_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_push && !w_wr;
         // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign code_valid = w_valid;
   assign code_data  = w_valid ? w_head[7:0] : 8'd0;
`ifdef PS2_EXT_DECODE_EN
   assign code_break = w_valid & w_head[9];
   assign code_ext   = w_valid & w_head[8];
`else
   assign code_break = 1'b0;
   assign code_ext   = 1'b0;
`endif
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule
